// File: rtl/hazard_ctl_if.sv
// Pipeline-to-hazard-controller bundle: stage register/control inputs and the
// enable, flush, forwarding and error outputs they produce.
interface hazard_ctl_if;
  logic [4:0] i_rs1_d;
  logic [4:0] i_rs2_d;
  logic [4:0] i_rs1_e;
  logic [4:0] i_rs2_e;
  logic [4:0] i_rd_e;
  logic [4:0] i_rd_m;
  logic [4:0] i_rd_w;
  logic       i_reg_wr_m;
  logic       i_reg_wr_w;
  logic [1:0] i_result_src_e;
  logic       i_pc_src_e;
  logic       i_mem_req_m;
  logic       i_mem_ready_m;
  logic       o_pc_clk_en;
  logic       o_if_id_clk_en;
  logic       o_id_ex_clk_en;
  logic       o_ex_mem_clk_en;
  logic       o_if_id_flush;
  logic       o_id_ex_flush;
  logic [1:0] o_fwd_a_e;
  logic [1:0] o_fwd_b_e;
  logic       o_mem_err;

  modport master (
    output i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w,
    output i_reg_wr_m, i_reg_wr_w, i_result_src_e, i_pc_src_e,
    output i_mem_req_m, i_mem_ready_m,
    input  o_pc_clk_en, o_if_id_clk_en, o_id_ex_clk_en, o_ex_mem_clk_en,
    input  o_if_id_flush, o_id_ex_flush, o_fwd_a_e, o_fwd_b_e, o_mem_err
  );

  modport slave (
    input  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w,
    input  i_reg_wr_m, i_reg_wr_w, i_result_src_e, i_pc_src_e,
    input  i_mem_req_m, i_mem_ready_m,
    output o_pc_clk_en, o_if_id_clk_en, o_id_ex_clk_en, o_ex_mem_clk_en,
    output o_if_id_flush, o_id_ex_flush, o_fwd_a_e, o_fwd_b_e, o_mem_err
  );
endinterface

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: stall/flush/forwarding plus memory-wait timeout trap (HAZARD_PERF_CNT_EN adds stall/flush counters).
// Latency: all controls combinational from state and inputs, zero cycles.
// Backpressure: a data-memory wait freezes every stage; a hung access parks in ERR until reset.
module hazard_ctl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  hazard_ctl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  logic       lw_stall;
  logic       mem_stall;
  logic       timeout_hit;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       if_id_fl;
  logic       id_ex_fl;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic wr_m,
                                         input logic wr_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else return 2'b00;
  endfunction

  assign lw_stall = (hz.i_result_src_e == 2'b01) && (hz.i_rd_e != 5'd0) &&
                    ((hz.i_rd_e == hz.i_rs1_d) || (hz.i_rd_e == hz.i_rs2_d));
  assign mem_stall = hz.i_mem_req_m && !hz.i_mem_ready_m;
  // Raised in the last tolerated wait cycle so the error shows together with the freeze.
  assign timeout_hit = (state == S_MEM_WAIT) && mem_stall &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_ex_en  = 1'b1;
    ex_mem_en = 1'b1;
    if_id_fl  = 1'b0;
    id_ex_fl  = 1'b0;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    if (!i_rst) begin
      fwd_a = fwd_sel(hz.i_rs1_e, hz.i_rd_m, hz.i_rd_w, hz.i_reg_wr_m, hz.i_reg_wr_w);
      fwd_b = fwd_sel(hz.i_rs2_e, hz.i_rd_m, hz.i_rd_w, hz.i_reg_wr_m, hz.i_reg_wr_w);
      // MEM_WAIT shares the RUN rules: the freeze row covers the stall, and
      // the release cycle falls through to branch/load-use handling.
      if (state == S_ERR || mem_stall) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
      end else if (hz.i_pc_src_e) begin
        if_id_fl = 1'b1;
        id_ex_fl = 1'b1;
      end else if (lw_stall) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_fl = 1'b1;
      end
    end
  end

  assign hz.o_pc_clk_en     = pc_en;
  assign hz.o_if_id_clk_en  = if_id_en;
  assign hz.o_id_ex_clk_en  = id_ex_en;
  assign hz.o_ex_mem_clk_en = ex_mem_en;
  assign hz.o_if_id_flush   = if_id_fl;
  assign hz.o_id_ex_flush   = id_ex_fl;
  assign hz.o_fwd_a_e       = fwd_a;
  assign hz.o_fwd_b_e       = fwd_b;
  assign hz.o_mem_err       = err_q || (timeout_hit && !i_rst);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (mem_stall) begin
            state    <= S_MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        S_MEM_WAIT: begin
          // Ready wins over the timeout when both land in the same cycle.
          if (!mem_stall) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_ERR: begin
          err_q <= 1'b1;
        end
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (!pc_en) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (id_ex_fl) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboarded bench for hazard_ctl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs every cycle.
module tb_hazard_ctl;
  logic clk;
  logic rst;

  hazard_ctl_if hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_ctl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .hz   (hif.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       wr_m, wr_w;
    logic [1:0] res_src;
    logic       pc_src, mem_req, mem_rdy, rst;
  } vec_t;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, fwd_a, fwd_b, mem_err}
  typedef struct packed {
    logic       pc, ifid, idex, exmem, ifid_fl, idex_fl;
    logic [1:0] fa, fb;
    logic       err;
  } exp_t;

  typedef struct {
    exp_t        e;
    string       nm;
    bit          perf;
    logic [31:0] sc;
    logic [31:0] fc;
  } sb_t;

  localparam exp_t X_RUN = 11'b1111_00_00_00_0;
  localparam exp_t X_FRZ = 11'b0000_00_00_00_0;
  localparam exp_t X_BR  = 11'b1111_11_00_00_0;
  localparam exp_t X_LU  = 11'b0011_01_00_00_0;
  localparam exp_t X_ERR = 11'b0000_00_00_00_1;

  sb_t sb_q[$];
  sb_t cur;
  exp_t got;
  int checks = 0;
  int passed = 0;

  task automatic apply(input vec_t v);
    hif.i_rs1_d        = v.rs1_d;
    hif.i_rs2_d        = v.rs2_d;
    hif.i_rs1_e        = v.rs1_e;
    hif.i_rs2_e        = v.rs2_e;
    hif.i_rd_e         = v.rd_e;
    hif.i_rd_m         = v.rd_m;
    hif.i_rd_w         = v.rd_w;
    hif.i_reg_wr_m     = v.wr_m;
    hif.i_reg_wr_w     = v.wr_w;
    hif.i_result_src_e = v.res_src;
    hif.i_pc_src_e     = v.pc_src;
    hif.i_mem_req_m    = v.mem_req;
    hif.i_mem_ready_m  = v.mem_rdy;
    rst                = v.rst;
  endtask

  task automatic step(input vec_t v, input exp_t e, input string nm, input bit chk,
                      input bit perf, input logic [31:0] sc, input logic [31:0] fc);
    sb_t s;
    @(posedge clk);
    #1;
    apply(v);
    if (chk) begin
      s.e = e; s.nm = nm; s.perf = perf; s.sc = sc; s.fc = fc;
      sb_q.push_back(s);
    end
  endtask

  task automatic chk_step(input vec_t v, input exp_t e, input string nm);
    step(v, e, nm, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      got = {hif.o_pc_clk_en, hif.o_if_id_clk_en, hif.o_id_ex_clk_en, hif.o_ex_mem_clk_en,
             hif.o_if_id_flush, hif.o_id_ex_flush, hif.o_fwd_a_e, hif.o_fwd_b_e, hif.o_mem_err};
      checks++;
      if (got === cur.e) passed++;
      else $display("FAIL %s: got %b expected %b", cur.nm, got, cur.e);
`ifdef HAZARD_PERF_CNT_EN
      if (cur.perf) begin
        checks++;
        if (stall_cnt === cur.sc && flush_cnt === cur.fc) passed++;
        else $display("FAIL %s_cnt: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                      cur.nm, stall_cnt, flush_cnt, cur.sc, cur.fc);
      end
`endif
    end
  end

  initial begin
    vec_t v;
    exp_t e;

    v = '0; v.rst = 1'b1;
    apply(v);

    // Reset forces run outputs even with every hazard condition present.
    v.mem_req = 1; v.rd_m = 5; v.wr_m = 1; v.rs1_e = 5;
    v.res_src = 2'b01; v.rd_e = 7; v.rs2_d = 7; v.pc_src = 1;
    chk_step(v, X_RUN, "reset_forced");

    v = '0; v.rd_m = 5; v.wr_m = 1; v.rd_w = 5; v.wr_w = 1; v.rs1_e = 5;
    e = X_RUN; e.fa = 2'b10; chk_step(v, e, "fwd_a_mem_wins");
    v.rd_m = 0;
    e = X_RUN; e.fa = 2'b01; chk_step(v, e, "fwd_a_wb");
    v = '0; v.rs1_e = 3; v.rs2_e = 9; v.rd_m = 9; v.wr_m = 1; v.rd_w = 3; v.wr_w = 1;
    e = X_RUN; e.fa = 2'b01; e.fb = 2'b10; chk_step(v, e, "fwd_b_mem");
    v = '0; v.rs1_e = 5; v.rs2_e = 5; v.rd_m = 5; v.wr_m = 0;
    chk_step(v, X_RUN, "fwd_wr_disabled");
    v = '0; v.wr_m = 1; v.wr_w = 1;
    chk_step(v, X_RUN, "fwd_x0_ignored");

    v = '0; v.res_src = 2'b01; v.rd_e = 7; v.rs2_d = 7;
    chk_step(v, X_LU, "load_use_rs2");
    v = '0; v.res_src = 2'b01; v.rd_e = 7; v.rs1_d = 7;
    chk_step(v, X_LU, "load_use_rs1");
    v = '0; v.res_src = 2'b01; v.rd_e = 0; v.rs2_d = 7;
    chk_step(v, X_RUN, "load_use_rd0");
    v = '0; v.res_src = 2'b10; v.rd_e = 7; v.rs2_d = 7;
    chk_step(v, X_RUN, "non_load_no_stall");
    v = '0; v.res_src = 2'b01; v.rd_e = 7; v.rs2_d = 7; v.pc_src = 1;
    chk_step(v, X_BR, "branch_over_lw");

    // Three-cycle wait with a branch held in EX, released on ready.
    v = '0; v.mem_req = 1; v.pc_src = 1;
    for (int i = 0; i < 3; i++) chk_step(v, X_FRZ, "mem_wait");
    v.mem_rdy = 1;
    chk_step(v, X_BR, "mem_ready_branch");
    v = '0;
    chk_step(v, X_RUN, "after_wait_idle");

    v = '0; v.mem_req = 1;
    chk_step(v, X_FRZ, "wait_req_drop_a");
    v.mem_req = 0;
    chk_step(v, X_RUN, "wait_req_drop_b");

    // Ready on the timeout cycle keeps the controller out of ERR.
    v = '0; v.mem_req = 1;
    for (int i = 0; i < 4; i++) chk_step(v, X_FRZ, "pre_timeout_wait");
    v.mem_rdy = 1;
    chk_step(v, X_RUN, "ready_beats_timeout");
    v = '0;
    chk_step(v, X_RUN, "no_err_after_ready");

    v = '0; v.mem_req = 1;
    for (int i = 0; i < 4; i++) chk_step(v, X_FRZ, "timeout_wait");
    for (int i = 0; i < 4; i++) chk_step(v, X_ERR, "timeout_err");
    v.mem_req = 0; v.mem_rdy = 1;
    chk_step(v, X_ERR, "err_sticky");
    v = '0; v.rst = 1;
    step(v, X_RUN, "", 1'b0, 1'b0, 32'd0, 32'd0);
    v = '0;
    chk_step(v, X_RUN, "err_cleared");
    v.mem_req = 1;
    chk_step(v, X_FRZ, "post_reset_wait");
    v.mem_req = 0;
    chk_step(v, X_RUN, "post_reset_release");

    v = '0; v.rst = 1;
    step(v, X_RUN, "", 1'b0, 1'b0, 32'd0, 32'd0);
    v = '0; v.res_src = 2'b01; v.rd_e = 7; v.rs2_d = 7;
    chk_step(v, X_LU, "perf_lu_1");
    chk_step(v, X_LU, "perf_lu_2");
    v = '0; v.pc_src = 1;
    chk_step(v, X_BR, "perf_branch");
    v = '0;
    step(v, X_RUN, "perf_idle", 1'b1, 1'b1, 32'd2, 32'd3);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline hazard controller; the producer of the clock-enable and flush controls consumed by the IF/ID and ID/EX stage registers and the PC register.
- Detects load-use hazards, taken branches/jumps and data-memory wait states, and generates EX-stage forwarding selects.
- Holds a small FSM with a wait-timeout counter that traps hung memory accesses.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering ERR (legal range 2..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_rs1_d, i_rs2_d  in  5  source regs in ID.
- i_rs1_e, i_rs2_e, i_rd_e  in  5  source/dest regs in EX.
- i_rd_m, i_rd_w  in  5  dest regs in MEM/WB.
- i_reg_wr_m, i_reg_wr_w  in  1  reg-write enables in MEM/WB.
- i_result_src_e  in  2  result select in EX; 2'b01 = load.
- i_pc_src_e  in  1  branch/jump taken, resolved in EX.
- i_mem_req_m  in  1  data-memory access active in MEM.
- i_mem_ready_m  in  1  data memory completes access this cycle.
- o_pc_clk_en  out  1  PC register enable.
- o_if_id_clk_en  out  1  IF/ID enable.
- o_id_ex_clk_en  out  1  ID/EX enable.
- o_ex_mem_clk_en  out  1  EX/MEM and MEM/WB enable.
- o_if_id_flush  out  1  IF/ID flush.
- o_id_ex_flush  out  1  ID/EX flush.
- o_fwd_a_e, o_fwd_b_e  out  2  forward select: 00 = regfile, 01 = WB result, 10 = MEM ALU result.
- o_mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Clock/reset: single clock i_clk; reset i_rst is synchronous and active-high. Reset sets state=RUN, wait_cnt=0, o_mem_err=0.
- Outputs are combinational from state and inputs, zero latency. While i_rst is high, outputs are forced: all clk_en=1, flushes=0, fwd=00.
- Forwarding for A (B identical using i_rs2_e):
  - 10 if i_reg_wr_m && i_rd_m!=0 && i_rd_m==i_rs1_e;
  - else 01 if i_reg_wr_w && i_rd_w!=0 && i_rd_w==i_rs1_e;
  - else 00. MEM wins over WB.
- lw_stall = (i_result_src_e==01) && i_rd_e!=0 && (i_rd_e==i_rs1_d || i_rd_e==i_rs2_d).
- mem_stall = i_mem_req_m && !i_mem_ready_m.
- RUN state, priority order:
  - mem_stall: all four clk_en=0, flushes=0. The taken branch in EX is held and re-evaluated after release.
  - else i_pc_src_e: all clk_en=1, o_if_id_flush=1, o_id_ex_flush=1. Overrides lw_stall.
  - else lw_stall: o_pc_clk_en=0, o_if_id_clk_en=0, o_id_ex_flush=1, others 1.
  - else: all clk_en=1, flushes=0.
- Transitions: RUN→MEM_WAIT when mem_stall; wait_cnt←1.
- MEM_WAIT state: same outputs as the mem_stall row while mem_stall holds; wait_cnt increments each cycle.
  - On i_mem_ready_m (or i_mem_req_m dropping): apply the RUN rules combinationally that cycle, go to RUN, wait_cnt←0.
  - If wait_cnt==MEM_TIMEOUT and still mem_stall: go to ERR.
- ERR state: all clk_en=0, flushes=0, o_mem_err=1. Exit only via i_rst. Ready arriving in the same cycle as the timeout does not enter ERR; ready has priority.
- wait_cnt never wraps; it saturates at MEM_TIMEOUT.
- Reset mid-MEM_WAIT or in ERR returns to RUN next edge and clears o_mem_err.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds ports o_stall_cnt (out, 32) and o_flush_cnt (out, 32).
  - o_stall_cnt increments on each cycle with o_pc_clk_en=0 outside reset.
  - o_flush_cnt increments on each cycle with o_id_ex_flush=1.
  - Both wrap modulo 2^32 and are cleared by i_rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Forwarding: i_rd_m=5, i_reg_wr_m=1, i_rd_w=5, i_reg_wr_w=1, i_rs1_e=5 → o_fwd_a_e=10. Same stimulus with i_rd_m=0 → 01.
- Load-use: i_result_src_e=01, i_rd_e=7, i_rs2_d=7 → o_pc_clk_en=0, o_if_id_clk_en=0, o_id_ex_flush=1. Same with i_rd_e=0 → no stall.
- Branch priority: i_pc_src_e=1 together with lw_stall conditions → both flushes=1, all clk_en=1.
- Memory wait: i_mem_req_m=1, i_mem_ready_m=0 for 3 cycles, then ready → all clk_en=0 for 3 cycles, 1 on the ready cycle, state back to RUN.
- Timeout: MEM_TIMEOUT=4, ready never asserted → o_mem_err=1 from the 5th stall cycle and persists. Then i_rst=1 for one cycle → o_mem_err=0, clk_en=1.
- HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 taken branch → o_stall_cnt=2, o_flush_cnt=3.
